// File: rtl/mem_arbiter.sv
// Round-robin arbiter serialising whole-line transactions from the D-cache (m0)
// and I-cache (m1) onto one memory port, with a one-cycle release bubble.
module mem_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int LINE_WIDTH = 256
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  m0_enable_i,
  input  logic                  m0_write_i,
  input  logic [ADDR_WIDTH-1:0] m0_addr_i,
  input  logic [LINE_WIDTH-1:0] m0_data_i,
  output logic [LINE_WIDTH-1:0] m0_data_o,
  output logic                  m0_ack_o,
  input  logic                  m1_enable_i,
  input  logic                  m1_write_i,
  input  logic [ADDR_WIDTH-1:0] m1_addr_i,
  input  logic [LINE_WIDTH-1:0] m1_data_i,
  output logic [LINE_WIDTH-1:0] m1_data_o,
  output logic                  m1_ack_o,
  output logic                  mem_enable_o,
  output logic                  mem_write_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [LINE_WIDTH-1:0] mem_data_o,
  input  logic [LINE_WIDTH-1:0] mem_data_i,
  input  logic                  mem_ack_i
);

  typedef enum logic [1:0] {IDLE, BUSY0, BUSY1, RELEASE} state_e;

  state_e                state_q, state_d;
  logic                  last_grant_q, last_grant_d;
  logic                  mem_write_q, mem_write_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [LINE_WIDTH-1:0] mem_data_q, mem_data_d;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    mem_write_d  = mem_write_q;
    mem_addr_d   = mem_addr_q;
    mem_data_d   = mem_data_q;
    case (state_q)
      IDLE: begin
        // m0 wins when alone or on a tie where m1 was served last
        if (m0_enable_i && (!m1_enable_i || last_grant_q)) begin
          state_d      = BUSY0;
          last_grant_d = 1'b0;
          mem_write_d  = m0_write_i;
          mem_addr_d   = m0_addr_i;
          mem_data_d   = m0_data_i;
        end else if (m1_enable_i) begin
          state_d      = BUSY1;
          last_grant_d = 1'b1;
          mem_write_d  = m1_write_i;
          mem_addr_d   = m1_addr_i;
          mem_data_d   = m1_data_i;
        end
      end
      BUSY0, BUSY1: if (mem_ack_i) state_d = RELEASE;
      RELEASE:      state_d = IDLE;
      default:      state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      mem_write_q  <= 1'b0;
      mem_addr_q   <= '0;
      mem_data_q   <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      mem_write_q  <= mem_write_d;
      mem_addr_q   <= mem_addr_d;
      mem_data_q   <= mem_data_d;
    end
  end

  // Enable comes only from registered state; acks are gated so a stray
  // memory ack outside a transaction never reaches a cache.
  assign mem_enable_o = (state_q == BUSY0) || (state_q == BUSY1);
  assign mem_write_o  = mem_write_q;
  assign mem_addr_o   = mem_addr_q;
  assign mem_data_o   = mem_data_q;
  assign m0_ack_o     = mem_ack_i && (state_q == BUSY0);
  assign m1_ack_o     = mem_ack_i && (state_q == BUSY1);
  assign m0_data_o    = mem_data_i;
  assign m1_data_o    = mem_data_i;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: vector table, directed corner sequences, and a
// randomized run against a transaction-level reference model.
module tb_mem_arbiter;
  localparam int AW = 32;
  localparam int LW = 256;

  logic          clk_i, rst_i;
  logic          m0_enable_i, m0_write_i, m1_enable_i, m1_write_i;
  logic [AW-1:0] m0_addr_i, m1_addr_i;
  logic [LW-1:0] m0_data_i, m1_data_i, m0_data_o, m1_data_o;
  logic          m0_ack_o, m1_ack_o;
  logic          mem_enable_o, mem_write_o, mem_ack_i;
  logic [AW-1:0] mem_addr_o;
  logic [LW-1:0] mem_data_o, mem_data_i;

  mem_arbiter #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .m0_enable_i(m0_enable_i), .m0_write_i(m0_write_i), .m0_addr_i(m0_addr_i),
    .m0_data_i(m0_data_i), .m0_data_o(m0_data_o), .m0_ack_o(m0_ack_o),
    .m1_enable_i(m1_enable_i), .m1_write_i(m1_write_i), .m1_addr_i(m1_addr_i),
    .m1_data_i(m1_data_i), .m1_data_o(m1_data_o), .m1_ack_o(m1_ack_o),
    .mem_enable_o(mem_enable_o), .mem_write_o(mem_write_o), .mem_addr_o(mem_addr_o),
    .mem_data_o(mem_data_o), .mem_data_i(mem_data_i), .mem_ack_i(mem_ack_i)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [LW-1:0] got, input logic [LW-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h @%0t", nm, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic wait_en(input string nm);
    int n = 0;
    while (mem_enable_o !== 1'b1 && n < 10) begin
      tick();
      n++;
    end
    chk(nm, LW'(mem_enable_o), LW'(1));
  endtask

  task automatic do_reset();
    rst_i = 1'b0;
    m0_enable_i = 1'b0; m1_enable_i = 1'b0; mem_ack_i = 1'b0;
    @(negedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b1;
    tick();
  endtask

  function automatic logic [LW-1:0] rand_line();
    logic [LW-1:0] v;
    for (int i = 0; i < LW / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  // Vector table: inputs applied for one cycle, outputs expected in that cycle
  typedef struct {
    logic en0, en1, ack;
    logic x_en, x_a0, x_a1, x_wr;
    logic [AW-1:0] x_addr;
  } vec_t;
  vec_t tbl[14];

  // Reference model: who owns the memory port, and whether the bubble is active
  int            own, last;
  bit            rel;
  logic          exp_wr;
  logic [AW-1:0] exp_addr;
  logic [LW-1:0] exp_data;

  task automatic model_reset();
    own = -1; rel = 0; last = 1;
  endtask

  task automatic model_step();
    int w;
    if (own >= 0) begin
      if (mem_ack_i) begin own = -1; rel = 1; end
    end else if (rel) begin
      rel = 0;
    end else begin
      w = -1;
      if (m0_enable_i && m1_enable_i) w = 1 - last;
      else if (m0_enable_i)           w = 0;
      else if (m1_enable_i)           w = 1;
      if (w == 0) begin exp_wr = m0_write_i; exp_addr = m0_addr_i; exp_data = m0_data_i; end
      if (w == 1) begin exp_wr = m1_write_i; exp_addr = m1_addr_i; exp_data = m1_data_i; end
      if (w >= 0) begin own = w; last = w; end
    end
  endtask

  localparam logic [LW-1:0] LA = {8{32'h1111_0000}};
  localparam logic [LW-1:0] LB = {8{32'h2222_0000}};
  localparam logic [LW-1:0] LC = {8{32'hC0DE_0000}};

  initial begin
    bit req[2], stale[2], seen[2];
    logic xa0, xa1;

    tbl[0]  = '{1, 1, 0, 0, 0, 0, 0, 32'h0};
    tbl[1]  = '{1, 1, 0, 1, 0, 0, 0, 32'h400};
    tbl[2]  = '{1, 1, 1, 1, 1, 0, 0, 32'h400};
    tbl[3]  = '{1, 1, 0, 0, 0, 0, 0, 32'h400};
    tbl[4]  = '{0, 1, 0, 0, 0, 0, 0, 32'h400};
    tbl[5]  = '{0, 1, 0, 1, 0, 0, 1, 32'h800};
    tbl[6]  = '{1, 1, 1, 1, 0, 1, 1, 32'h800};
    tbl[7]  = '{1, 1, 1, 0, 0, 0, 1, 32'h800};
    tbl[8]  = '{1, 1, 0, 0, 0, 0, 1, 32'h800};
    tbl[9]  = '{1, 1, 0, 1, 0, 0, 0, 32'h400};
    tbl[10] = '{1, 1, 1, 1, 1, 0, 0, 32'h400};
    tbl[11] = '{0, 1, 0, 0, 0, 0, 0, 32'h400};
    tbl[12] = '{0, 0, 1, 0, 0, 0, 0, 32'h400};
    tbl[13] = '{0, 0, 0, 0, 0, 0, 0, 32'h400};

    // Reset held with both requesters and a memory ack active
    rst_i = 1'b0;
    m0_enable_i = 1'b1; m1_enable_i = 1'b1; mem_ack_i = 1'b1;
    m0_write_i = 1'b1; m1_write_i = 1'b1;
    m0_addr_i = 32'h400; m1_addr_i = 32'h800;
    m0_data_i = LA; m1_data_i = LB; mem_data_i = LC;
    @(negedge clk_i);
    @(negedge clk_i);
    chk("rst_mem_en", LW'(mem_enable_o), 0);
    chk("rst_mem_wr", LW'(mem_write_o), 0);
    chk("rst_mem_addr", LW'(mem_addr_o), 0);
    chk("rst_mem_data", mem_data_o, 0);
    chk("rst_ack0", LW'(m0_ack_o), 0);
    chk("rst_ack1", LW'(m1_ack_o), 0);
    m0_enable_i = 1'b0; m1_enable_i = 1'b0; mem_ack_i = 1'b0;
    m0_write_i = 1'b0;
    rst_i = 1'b1;
    tick();

    for (int i = 0; i < 14; i++) begin
      m0_enable_i = tbl[i].en0; m1_enable_i = tbl[i].en1; mem_ack_i = tbl[i].ack;
      @(negedge clk_i);
      chk($sformatf("tbl%0d_en", i), LW'(mem_enable_o), LW'(tbl[i].x_en));
      chk($sformatf("tbl%0d_ack0", i), LW'(m0_ack_o), LW'(tbl[i].x_a0));
      chk($sformatf("tbl%0d_ack1", i), LW'(m1_ack_o), LW'(tbl[i].x_a1));
      chk($sformatf("tbl%0d_wr", i), LW'(mem_write_o), LW'(tbl[i].x_wr));
      chk($sformatf("tbl%0d_addr", i), LW'(mem_addr_o), LW'(tbl[i].x_addr));
      if (tbl[i].x_a0 || tbl[i].x_a1)
        chk($sformatf("tbl%0d_rdata", i), tbl[i].x_a0 ? m0_data_o : m1_data_o, LC);
      tick();
    end

    // m0 read, memory answers 10 cycles after enable
    do_reset();
    m0_enable_i = 1'b1; m0_write_i = 1'b0; m0_addr_i = 32'h400;
    wait_en("rd_grant");
    chk("rd_addr", LW'(mem_addr_o), LW'(32'h400));
    chk("rd_wr", LW'(mem_write_o), 0);
    repeat (10) tick();
    mem_ack_i = 1'b1; mem_data_i = {8{32'hA5A5_0001}};
    @(negedge clk_i);
    chk("rd_ack0", LW'(m0_ack_o), 1);
    chk("rd_ack1", LW'(m1_ack_o), 0);
    chk("rd_data", m0_data_o, {8{32'hA5A5_0001}});
    tick();
    mem_ack_i = 1'b0; m0_enable_i = 1'b0;
    @(negedge clk_i);
    chk("rd_ack_pulse", LW'(m0_ack_o), 0);
    chk("rd_gap1", LW'(mem_enable_o), 0);
    tick();
    @(negedge clk_i);
    chk("rd_gap2", LW'(mem_enable_o), 0);
    tick();

    // m1 write with the address changing mid-transaction
    m1_enable_i = 1'b1; m1_write_i = 1'b1; m1_addr_i = 32'h800;
    m1_data_i = {8{32'hDEAD_BEEF}};
    wait_en("wr_grant");
    chk("wr_flag", LW'(mem_write_o), 1);
    chk("wr_data", mem_data_o, {8{32'hDEAD_BEEF}});
    m1_addr_i = 32'hC00;
    repeat (3) begin
      tick();
      @(negedge clk_i);
      chk("wr_addr_hold", LW'(mem_addr_o), LW'(32'h800));
    end
    tick();
    mem_ack_i = 1'b1;
    @(negedge clk_i);
    chk("wr_ack1", LW'(m1_ack_o), 1);
    chk("wr_ack0", LW'(m0_ack_o), 0);
    chk("wr_addr_at_ack", LW'(mem_addr_o), LW'(32'h800));
    tick();
    mem_ack_i = 1'b0; m1_enable_i = 1'b0;
    tick();

    // Stale enable: m0 keeps enable through the release cycle only
    m0_enable_i = 1'b1; m0_addr_i = 32'h1000;
    wait_en("stale_grant");
    mem_ack_i = 1'b1;
    @(negedge clk_i);
    chk("stale_ack0", LW'(m0_ack_o), 1);
    tick();
    mem_ack_i = 1'b0;
    @(negedge clk_i);
    chk("stale_release", LW'(mem_enable_o), 0);
    tick();
    m0_enable_i = 1'b0;
    repeat (3) begin
      @(negedge clk_i);
      chk("stale_no_regrant", LW'(mem_enable_o), 0);
      tick();
    end

    // Spurious memory ack while idle
    mem_ack_i = 1'b1;
    @(negedge clk_i);
    chk("spur_ack0", LW'(m0_ack_o), 0);
    chk("spur_ack1", LW'(m1_ack_o), 0);
    tick();
    mem_ack_i = 1'b0;
    @(negedge clk_i);
    chk("spur_idle", LW'(mem_enable_o), 0);
    tick();

    // Contention: both held high, grants must alternate starting with m0
    do_reset();
    m0_enable_i = 1'b1; m1_enable_i = 1'b1;
    m0_addr_i = 32'h400; m1_addr_i = 32'h800;
    for (int t = 0; t < 4; t++) begin
      wait_en($sformatf("rr%0d_grant", t));
      chk($sformatf("rr%0d_addr", t), LW'(mem_addr_o), LW'((t % 2) ? 32'h800 : 32'h400));
      tick();
      mem_ack_i = 1'b1;
      @(negedge clk_i);
      chk($sformatf("rr%0d_ack", t), LW'((t % 2) ? m1_ack_o : m0_ack_o), 1);
      tick();
      mem_ack_i = 1'b0;
    end

    // Reset in the middle of an m1 transaction
    m0_enable_i = 1'b0; m1_addr_i = 32'h900;
    wait_en("mrst_grant");
    @(negedge clk_i);
    rst_i = 1'b0;
    #1;
    mem_ack_i = 1'b1;
    #1;
    chk("mrst_en_drop", LW'(mem_enable_o), 0);
    chk("mrst_no_ack1", LW'(m1_ack_o), 0);
    mem_ack_i = 1'b0; m1_enable_i = 1'b0;
    @(negedge clk_i);
    rst_i = 1'b1;
    tick();

    // Randomized traffic against the reference model
    do_reset();
    model_reset();
    req[0] = 0; req[1] = 0; stale[0] = 0; stale[1] = 0;
    for (int c = 0; c < 3000; c++) begin
      m0_addr_i = $urandom; m1_addr_i = $urandom;
      m0_write_i = 1'($urandom); m1_write_i = 1'($urandom);
      m0_data_i = rand_line(); m1_data_i = rand_line(); mem_data_i = rand_line();
      mem_ack_i = (own >= 0) ? ($urandom_range(2) == 0) : ($urandom_range(7) == 0);
      m0_enable_i = req[0] | stale[0];
      m1_enable_i = req[1] | stale[1];
      @(negedge clk_i);
      xa0 = mem_ack_i && (own == 0);
      xa1 = mem_ack_i && (own == 1);
      chk("rnd_en", LW'(mem_enable_o), LW'(own >= 0));
      chk("rnd_ack0", LW'(m0_ack_o), LW'(xa0));
      chk("rnd_ack1", LW'(m1_ack_o), LW'(xa1));
      chk("rnd_pass", m1_data_o, mem_data_i);
      if (own >= 0) begin
        chk("rnd_wr", LW'(mem_write_o), LW'(exp_wr));
        chk("rnd_addr", LW'(mem_addr_o), LW'(exp_addr));
        chk("rnd_data", mem_data_o, exp_data);
      end
      seen[0] = xa0; seen[1] = xa1;
      @(posedge clk_i);
      model_step();
      #1;
      for (int i = 0; i < 2; i++) begin
        if (seen[i]) begin
          req[i] = 0;
          stale[i] = ($urandom_range(3) == 0);
        end else begin
          stale[i] = 0;
          if (!req[i] && $urandom_range(2) == 0) req[i] = 1;
        end
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
